// File: rtl/regfile_sb.sv
// Scoreboarded register file: NRD combinational read ports, NWR prioritised write ports,
// tagged reservations, a global reservation flush and a registered pending-register count.
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    parameter int TAGW  = 3,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD-1:0]      rd_valid,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_reg,
    input  logic [TAGW-1:0]     rsv_tag,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_reg,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NWR*TAGW-1:0] wr_tag,
    input  logic                flush,
    output logic [AW:0]         pend_cnt
);
    logic [XLEN-1:0]  data_q [1:NREGS-1];
    logic [TAGW-1:0]  tag_q  [1:NREGS-1];
    logic [NREGS-1:1] valid_q;

    logic [NREGS-1:1] wr_hit;
    logic [NREGS-1:1] wr_commit;
    logic [NREGS-1:1] valid_d;
    logic [XLEN-1:0]  wr_sel [1:NREGS-1];
    logic [TAGW-1:0]  tag_d  [1:NREGS-1];
    logic [AW:0]      pend_d;

    always_comb begin
        for (int r = 1; r < NREGS; r++) begin
            wr_hit[r]    = 1'b0;
            wr_commit[r] = 1'b0;
            wr_sel[r]    = '0;
            // scan high to low so the lowest-index matching port assigns last and wins
            for (int j = NWR - 1; j >= 0; j--) begin
                if (wr_en[j] && (wr_reg[j*AW +: AW] == AW'(r))) begin
                    wr_hit[r]    = 1'b1;
                    wr_sel[r]    = wr_data[j*XLEN +: XLEN];
                    wr_commit[r] = valid_q[r] || (wr_tag[j*TAGW +: TAGW] == tag_q[r]);
                end
            end
        end
    end

    always_comb begin
        pend_d = '0;
        for (int r = 1; r < NREGS; r++) begin
            valid_d[r] = valid_q[r] | wr_commit[r] | flush;
            tag_d[r]   = tag_q[r];
            // a new reservation beats any commit or flush on the same register
            if (rsv_en && (rsv_reg == AW'(r))) begin
                valid_d[r] = 1'b0;
                tag_d[r]   = rsv_tag;
            end
            pend_d = pend_d + {{AW{1'b0}}, ~valid_d[r]};
        end
    end

    always_comb begin
        rd_valid = '1;
        rd_data  = '0;
        if (reset_n) begin
            for (int i = 0; i < NRD; i++) begin
                for (int r = 1; r < NREGS; r++) begin
                    if (rd_addr[i*AW +: AW] == AW'(r)) begin
                        rd_valid[i]             = valid_q[r] | wr_commit[r];
                        rd_data[i*XLEN +: XLEN] = wr_hit[r] ? wr_sel[r] : data_q[r];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q  <= '1;
            pend_cnt <= '0;
            for (int r = 1; r < NREGS; r++) begin
                data_q[r] <= '0;
                tag_q[r]  <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            pend_cnt <= pend_d;
            for (int r = 1; r < NREGS; r++) begin
                if (wr_hit[r]) begin
                    data_q[r] <= wr_sel[r];
                end
                tag_q[r] <= tag_d[r];
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vectors with literal checks plus a per-cycle
// comparison against a behavioural scoreboard model.
module tb_regfile_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int TAGW  = 3;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD-1:0]      rd_valid;
    logic [NRD*XLEN-1:0] rd_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_reg;
    logic [TAGW-1:0]     rsv_tag;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_reg;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NWR*TAGW-1:0] wr_tag;
    logic                flush;
    logic [AW:0]         pend_cnt;

    int errors = 0;
    int checks = 0;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .TAGW(TAGW)) dut (
        .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .rd_data(rd_data), .rsv_en(rsv_en), .rsv_reg(rsv_reg), .rsv_tag(rsv_tag),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .wr_tag(wr_tag),
        .flush(flush), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    // architectural model
    logic [XLEN-1:0] m_data  [NREGS];
    logic            m_valid [NREGS];
    logic [TAGW-1:0] m_tag   [NREGS];
    int              m_pend;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_data[r]  = '0;
            m_valid[r] = 1'b1;
            m_tag[r]   = '0;
        end
        m_pend = 0;
    endtask

    // lowest write port targeting a non-zero register, or -1
    function automatic int winner(input int r);
        if (r == 0) return -1;
        for (int j = 0; j < NWR; j++)
            if (wr_en[j] && int'(wr_reg[j*AW +: AW]) == r) return j;
        return -1;
    endfunction

    function automatic bit commits(input int r, input int j);
        return m_valid[r] || (wr_tag[j*TAGW +: TAGW] == m_tag[r]);
    endfunction

    task automatic exp_read(input int a, output logic v, output logic [XLEN-1:0] d);
        int j;
        j = winner(a);
        if (a == 0) begin
            v = 1'b1; d = '0;
        end else if (j >= 0) begin
            d = wr_data[j*XLEN +: XLEN];
            v = commits(a, j) ? 1'b1 : m_valid[a];
        end else begin
            v = m_valid[a]; d = m_data[a];
        end
    endtask

    task automatic m_edge();
        logic [XLEN-1:0] nd [NREGS];
        logic            nv [NREGS];
        logic [TAGW-1:0] nt [NREGS];
        int j;
        for (int r = 0; r < NREGS; r++) begin
            nd[r] = m_data[r]; nv[r] = m_valid[r]; nt[r] = m_tag[r];
        end
        for (int r = 1; r < NREGS; r++) begin
            j = winner(r);
            if (j >= 0) begin
                nd[r] = wr_data[j*XLEN +: XLEN];
                if (commits(r, j)) nv[r] = 1'b1;
            end
        end
        if (flush)
            for (int r = 1; r < NREGS; r++) nv[r] = 1'b1;
        if (rsv_en && rsv_reg != 0) begin
            nv[rsv_reg] = 1'b0;
            nt[rsv_reg] = rsv_tag;
        end
        m_pend = 0;
        for (int r = 0; r < NREGS; r++) begin
            m_data[r] = nd[r]; m_valid[r] = nv[r]; m_tag[r] = nt[r];
            if (r != 0 && !nv[r]) m_pend++;
        end
    endtask

    always @(posedge clk) if (reset_n) m_edge();

    always @(negedge clk) begin
        logic v;
        logic [XLEN-1:0] d;
        if (reset_n) begin
            for (int i = 0; i < NRD; i++) begin
                exp_read(int'(rd_addr[i*AW +: AW]), v, d);
                chk($sformatf("model_rd_valid%0d", i), 64'(rd_valid[i]), 64'(v));
                chk($sformatf("model_rd_data%0d", i), 64'(rd_data[i*XLEN +: XLEN]), 64'(d));
            end
            chk("model_pend_cnt", 64'(pend_cnt), 64'(m_pend));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rsv_en = 0; rsv_reg = 0; rsv_tag = 0;
        wr_en = 0; wr_reg = 0; wr_data = 0; wr_tag = 0;
        flush = 0;
    endtask

    task automatic set_wr(input int j, input int r, input logic [XLEN-1:0] d, input int t);
        wr_en[j]               = 1'b1;
        wr_reg[j*AW +: AW]     = AW'(r);
        wr_data[j*XLEN +: XLEN] = d;
        wr_tag[j*TAGW +: TAGW] = TAGW'(t);
    endtask

    task automatic set_rsv(input int r, input int t);
        rsv_en = 1'b1; rsv_reg = AW'(r); rsv_tag = TAGW'(t);
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        set_rd(5, 9);
        m_reset();
        #1;
        chk("in_reset_rd_valid", 64'(rd_valid), 64'h3);
        chk("in_reset_rd_data", 64'(rd_data), 64'h0);
        #11 reset_n = 1'b1;
        step();

        // every register reads valid/0 after reset
        for (int a = 0; a < NREGS; a++) begin
            set_rd(a, NREGS - 1 - a);
            #1;
            chk("rst_rd_valid", 64'(rd_valid), 64'h3);
            chk("rst_rd_data", 64'(rd_data), 64'h0);
        end
        chk("rst_pend", 64'(pend_cnt), 64'h0);

        // x0 ignores writes
        set_rd(0, 0);
        set_wr(0, 0, 32'hDEADBEEF, 0);
        #2;
        chk("x0_fwd_data", 64'(rd_data[31:0]), 64'h0);
        step();
        idle();
        #2;
        chk("x0_data", 64'(rd_data[31:0]), 64'h0);
        chk("x0_valid", 64'(rd_valid[0]), 64'h1);

        // reserve x5 then matching-tag writeback on port 1
        set_rsv(5, 2);
        step();
        idle();
        set_rd(5, 0);
        #2;
        chk("x5_rsv_valid", 64'(rd_valid[0]), 64'h0);
        chk("x5_rsv_pend", 64'(pend_cnt), 64'h1);
        set_wr(1, 5, 32'h1234, 2);
        #2;
        chk("x5_fwd_valid", 64'(rd_valid[0]), 64'h1);
        chk("x5_fwd_data", 64'(rd_data[31:0]), 64'h1234);
        step();
        idle();
        #2;
        chk("x5_wb_valid", 64'(rd_valid[0]), 64'h1);
        chk("x5_wb_pend", 64'(pend_cnt), 64'h0);

        // superseded producer on x7
        set_rsv(7, 1);
        step();
        set_rsv(7, 4);
        step();
        idle();
        set_rd(7, 7);
        set_wr(0, 7, 32'hAA, 1);
        #2;
        chk("x7_stale_fwd_valid", 64'(rd_valid[0]), 64'h0);
        chk("x7_stale_fwd_data", 64'(rd_data[31:0]), 64'hAA);
        step();
        idle();
        #2;
        chk("x7_stale_valid", 64'(rd_valid[1]), 64'h0);
        chk("x7_stale_data", 64'(rd_data[63:32]), 64'hAA);
        chk("x7_stale_pend", 64'(pend_cnt), 64'h1);
        set_wr(0, 7, 32'hBB, 4);
        #2;
        chk("x7_new_fwd_valid", 64'(rd_valid[0]), 64'h1);
        step();
        idle();
        #2;
        chk("x7_new_data", 64'(rd_data[31:0]), 64'hBB);
        chk("x7_new_pend", 64'(pend_cnt), 64'h0);

        // duplicate destination: port 0 wins
        set_rd(9, 9);
        set_wr(0, 9, 32'h11, 0);
        set_wr(1, 9, 32'h22, 0);
        #2;
        chk("x9_fwd_p0", 64'(rd_data[31:0]), 64'h11);
        chk("x9_fwd_p1", 64'(rd_data[63:32]), 64'h11);
        step();
        idle();
        #2;
        chk("x9_stored", 64'(rd_data[31:0]), 64'h11);

        // pend_cnt climbs, then flush with a same-cycle reserve
        set_rsv(3, 1);
        step();
        #1 chk("pend_1", 64'(pend_cnt), 64'h1);
        set_rsv(4, 1);
        step();
        #1 chk("pend_2", 64'(pend_cnt), 64'h2);
        set_rsv(6, 1);
        step();
        #1 chk("pend_3", 64'(pend_cnt), 64'h3);
        set_rsv(8, 3);
        flush = 1'b1;
        step();
        idle();
        set_rd(3, 8);
        #2;
        chk("flush_x3_valid", 64'(rd_valid[0]), 64'h1);
        chk("flush_x8_valid", 64'(rd_valid[1]), 64'h0);
        chk("flush_rsv_pend", 64'(pend_cnt), 64'h1);
        flush = 1'b1;
        step();
        idle();
        #2;
        chk("flush_alone_pend", 64'(pend_cnt), 64'h0);

        // reserve and stale write to x10 in the same cycle
        set_rd(10, 10);
        set_rsv(10, 5);
        set_wr(0, 10, 32'h55, 0);
        step();
        idle();
        #2;
        chk("x10_valid", 64'(rd_valid[0]), 64'h0);
        chk("x10_data", 64'(rd_data[31:0]), 64'h55);
        chk("x10_pend", 64'(pend_cnt), 64'h1);
        set_wr(1, 10, 32'h66, 5);
        #2;
        chk("x10_tag5_fwd_valid", 64'(rd_valid[1]), 64'h1);
        step();
        idle();

        // scoreboard-checked mixed traffic on a small register window
        for (int n = 0; n < 200; n++) begin
            idle();
            set_rd($urandom_range(0, 7), $urandom_range(0, 7));
            for (int j = 0; j < NWR; j++)
                if ($urandom_range(0, 1) == 1)
                    set_wr(j, $urandom_range(0, 7), $urandom, $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) set_rsv($urandom_range(0, 7), $urandom_range(0, 3));
            flush = ($urandom_range(0, 15) == 0);
            step();
        end
        idle();

        // asynchronous reset mid-cycle with pending state
        set_rsv(11, 2);
        set_wr(0, 12, 32'h777, 0);
        step();
        idle();
        set_rd(11, 12);
        #1 reset_n = 1'b0;
        m_reset();
        #1;
        chk("async_rst_pend", 64'(pend_cnt), 64'h0);
        chk("async_rst_valid", 64'(rd_valid), 64'h3);
        chk("async_rst_data", 64'(rd_data), 64'h0);
        #1 reset_n = 1'b1;
        #1;
        chk("post_rst_x11_valid", 64'(rd_valid[0]), 64'h1);
        chk("post_rst_x12_data", 64'(rd_data[63:32]), 64'h0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised scoreboarded integer register file; successor to the fixed 2-read/2-write file.
- Generalised in data width, register count, read-port count and write-port count.
- Adds tagged reservations: a late write from a superseded producer cannot clear a newer reservation.
- Adds a global flush of reservations and a live count of pending registers.
- Sits between decode (reads, reserve) and the writeback/LSU paths (write ports).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, architectural registers incl. x0; power of two, >=2
NRD, 2, number of combinational read ports
NWR, 2, number of write ports; lower index = higher priority
TAGW, 3, reservation tag width
AW, $clog2(NREGS), register address width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
rd_valid  out  NRD  per-port operand ready
rd_data  out  NRD*XLEN  per-port operand data
rsv_en  in  1  reserve rsv_reg for a new producer
rsv_reg  in  AW  register to reserve
rsv_tag  in  TAGW  producer tag recorded for rsv_reg
wr_en  in  NWR  per-port write enable
wr_reg  in  NWR*AW  per-port destination
wr_data  in  NWR*XLEN  per-port data
wr_tag  in  NWR*TAGW  per-port producer tag
flush  in  1  clear all reservations (pipeline flush)
pend_cnt  out  AW+1  number of registers currently reserved

Behaviour:
- State per register r in 1..NREGS-1: data[r] (XLEN), valid[r], tag[r] (TAGW). x0 has no storage.
- Reset (async, reset_n=0): data=0, valid=1, tag=0 for all r; pend_cnt=0. Reads during reset see data 0, valid 1.
- Reads are combinational, evaluated per port in this order:
  - addr==0: valid=1, data=0.
  - Else if any wr_en[j] with wr_reg[j]==addr: data = wdata of lowest such j. valid=1 if that port "commits" (see below), else valid[addr].
  - Else: valid[addr], data[addr].
- Commit rule: write port j commits to r when wr_en[j], wr_reg[j]==r!=0, and (valid[r]==1 or wr_tag[j]==tag[r]).
- Clock edge, applied in this order:
  - a) Data update: if any wr_en[j] targets r!=0, data[r] <= wdata of lowest such j (stale-tag writes still update data).
  - b) Valid update: if the lowest-index port targeting r commits, valid[r] <= 1.
  - c) flush: valid[all] <= 1. Tags are unchanged.
  - d) rsv_en && rsv_reg!=0: valid[rsv_reg] <= 0, tag[rsv_reg] <= rsv_tag. Overrides a), b) and c) for that register's valid/tag. Data from a) is still taken.
- Writes or reserves to x0 are ignored.
- Re-reserving an already reserved register overwrites its tag. The older producer's write then no longer commits.
- pend_cnt is a registered count of registers with valid==0 after the edge:
  - Increments on a reserve of a previously valid register.
  - Decrements per committed write that sets valid.
  - Net change computed in one cycle.
  - flush alone → 0; flush+reserve → 1.
  - Never exceeds NREGS-1.
- Simultaneous write and reserve to the same register: result is reserved (valid=0), new tag, written data.
- Duplicate wr_reg across ports: lowest index wins for both data and commit decision. Higher ports to the same register are dropped.
- Reset asserted mid-operation immediately restores the reset state; pending reservations are lost.

Test Plan:
- Reset, then read x0..x31 on both ports → every rd_valid=1, rd_data=0, pend_cnt=0. Write x0=0xDEADBEEF via port 0 → read x0 still 0, valid 1.
- Reserve x5 tag 2, next cycle read x5 → rd_valid=0, pend_cnt=1. Port 1 writes x5=0x1234 tag 2 → same-cycle read valid=1, data 0x1234. Next cycle stored valid=1, pend_cnt=0.
- Reserve x7 tag 1, then re-reserve x7 tag 4. Port 0 writes x7=0xAA tag 1 → rd_valid=0, data 0xAA stored, pend_cnt=1. Write x7=0xBB tag 4 → valid=1, pend_cnt=0.
- Both ports write x9 same cycle (p0=0x11, p1=0x22) → forwarded and stored data 0x11.
- Reserve x3, x4, x6 over three cycles (pend_cnt 1,2,3). Then flush with reserve x8 in the same cycle → x3/x4/x6 valid, x8 invalid, pend_cnt=1.
- Same-cycle reserve x10 tag 5 and port 0 write x10=0x55 tag 0 on a valid x10 → x10 invalid, tag 5, data 0x55, pend_cnt=1. Assert reset_n=0 mid-stream → pend_cnt=0 and all regs valid/0 without waiting for a clock edge.
